muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide execute unit with valid/ready handshakes.
//  Sits beside the single-cycle ALU in EX and takes the instruction word.
//  It decodes funct3 and runs a radix-2 shift-add multiply or a restoring divide.
//  Divide-by-zero and signed overflow complete on an early-out path.
//  The pipeline stalls on o_ready/o_valid and kills work with i_flush.
// PARAMETERS
//  XLEN      32  operand/result width; must be a power of two >= 8
//  EARLY_OUT 1   1 = div-by-zero/overflow finish in 1 cycle; 0 = they take full latency
// PORTS
//  i_clk          in   1     clock, rising edge
//  i_rst_n        in   1     reset, asynchronous assert, active-low
//  i_valid        in   1     request valid
//  o_ready        out  1     unit can accept; equals (state==IDLE)
//  i_instruction  in   32    M-ext instruction; only [14:12] (funct3) is used; caller guarantees funct7=7'b0000001
//  i_op1          in   XLEN  rs1 value
//  i_op2          in   XLEN  rs2 value
//  i_flush        in   1     kill in-flight op; priority over everything except reset
//  o_valid        out  1     result valid; held until accepted
//  i_ready        in   1     consumer accepts result
//  o_result       out  XLEN  result; stable while o_valid=1
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE, o_valid=0, o_result=0, counter=0, o_ready=1 once state=IDLE.
//  Reset mid-operation: the operation is discarded with no result.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: i_valid&o_ready (cycle t) latches funct3 and operand magnitudes, plus the sign-fix flags.
//         Next state is BUSY, or DONE if the early-out condition holds (EARLY_OUT=1).
//   BUSY: one iteration per cycle for exactly XLEN cycles (t+1..t+XLEN).
//         The counter is $clog2(XLEN)+1 bits wide and counts down to 0.
//         On the last iteration the sign-fixed result is written to o_result; next state is DONE.
//   DONE: o_valid=1 from cycle t+XLEN+1.
//         If i_ready=1, go to IDLE next cycle; new work is accepted no earlier than the following cycle.
//         While i_ready=0, hold in DONE with o_result stable.
//  i_flush=1 in any state: next state is IDLE, o_valid drops next cycle and no result is produced.
//   A flush in the same cycle as i_valid&o_ready wins; that request is not accepted.
//  funct3: 000 MUL (low XLEN bits), 001 MULH (s*s high), 010 MULHSU (s*u high), 011 MULHU (u*u high).
//   100 DIV, 101 DIVU, 110 REM, 111 REMU.
//  Multiply: the 2*XLEN product is built from unsigned magnitudes.
//   The product is negated iff the operand signs differ (signed operands only).
//   The low or high half is then selected.
//  Divide: restoring division on magnitudes.
//   The quotient is negated iff the signs differ; the remainder takes the dividend's sign.
//  Divide by zero: quotient = all ones; remainder = op1.
//  Signed overflow (op1 = 1<<(XLEN-1), op2 = all ones, DIV/REM): quotient = op1; remainder = 0.
//  Early-out (EARLY_OUT=1): these two cases go IDLE->DONE, so o_valid is asserted at t+1.
//  The multiply path has no early-out; its latency is always XLEN+1.
//  All arithmetic is modulo 2^XLEN (product 2^(2*XLEN)); no exceptions or flags are raised.
// STRUCTURE
//  Shared header rv_defs.vh holds:
//   funct3 localparams FUNCT3_MUL..FUNCT3_REMU, and funct7 M-extension localparam 7'b0000001;
//   state encoding localparams ST_IDLE/ST_BUSY/ST_DONE, also used by the hazard unit.
//  One sub-module: muldiv_step, combinational single iteration.
//   Inputs: mode, accumulator, remainder, operand.
//   Outputs: next accumulator, next remainder.
//   Keeps the FSM/counter/sign-fix logic in muldiv_unit separate.
// TESTING
//  Outputs below are for XLEN=32 with an idle consumer (i_ready=1) unless stated.
//  MUL 7 * 0xFFFFFFFD (-3), accepted at t -> o_valid at t+33, o_result=0xFFFFFFEB.
//  MULH 0x80000000*0x80000000 -> 0x40000000.
//   MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//   MULHU same operands -> 0xFFFFFFFE.
//  DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
//   REM of the same operands -> 0xFFFFFFFF.
//   DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
//  DIVU 5/0 -> 0xFFFFFFFF at t+1 and REM 5/0 -> 5.
//   DIV 0x80000000/0xFFFFFFFF -> 0x80000000, with REM -> 0.
//   Repeat with EARLY_OUT=0: same values at t+33.
//  i_flush at t+10 of a DIV -> o_valid never rises, o_ready=1 at t+11.
//   A new MULHU accepted at t+11 gives o_valid at t+44.
//  Backpressure: i_ready=0 for 5 cycles after o_valid -> o_result/o_valid stable and o_ready=0.
//   i_ready=1 -> IDLE next cycle.
//   Assert i_rst_n=0 mid-BUSY -> o_valid=0 immediately and the FSM is IDLE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: funct3 decode,
// FSM states (also visible to the hazard unit) and iteration modes.
package muldiv_pkg;

    typedef enum logic [2:0] {
        FUNCT3_MUL    = 3'b000,
        FUNCT3_MULH   = 3'b001,
        FUNCT3_MULHSU = 3'b010,
        FUNCT3_MULHU  = 3'b011,
        FUNCT3_DIV    = 3'b100,
        FUNCT3_DIVU   = 3'b101,
        FUNCT3_REM    = 3'b110,
        FUNCT3_REMU   = 3'b111
    } funct3_e;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    function automatic logic op1_signed(input funct3_e f);
        return f inside {FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_DIV, FUNCT3_REM};
    endfunction

    function automatic logic op2_signed(input funct3_e f);
        return f inside {FUNCT3_MUL, FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM};
    endfunction

    function automatic logic is_div(input funct3_e f);
        return f inside {FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM, FUNCT3_REMU};
    endfunction

    function automatic logic is_rem(input funct3_e f);
        return f inside {FUNCT3_REM, FUNCT3_REMU};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Multiply: acc = product high half, rem = multiplier / product low half.
// Divide:   acc = dividend shifting into quotient, rem = partial remainder.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  step_mode_e      mode,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] acc_next,
    output logic [XLEN-1:0] rem_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum      = {1'b0, acc} + (rem[0] ? {1'b0, operand} : '0);
        shifted  = {rem, acc[XLEN-1]};
        diff     = shifted - {1'b0, operand};
        acc_next = acc;
        rem_next = rem;
        if (mode == STEP_MUL) begin
            acc_next = sum[XLEN:1];
            rem_next = {sum[0], rem[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            // partial remainder stays below the divisor, so a clear top bit means no borrow
            rem_next = diff[XLEN-1:0];
            acc_next = {acc[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN-1:0];
            acc_next = {acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit with valid/ready handshakes,
// XLEN-cycle iteration and an optional single-cycle path for div-by-zero/overflow.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instruction,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned     CNT_W   = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state;
    state_e            state_next;
    logic [CNT_W-1:0]  cnt;
    funct3_e           f3;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   opnd;
    logic              neg_main;
    logic              neg_rem;

    funct3_e           req_f3;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              overflow;
    logic              early;
    logic [XLEN-1:0]   special;
    logic              accept;
    logic              last_iter;

    step_mode_e        step_mode;
    logic [XLEN-1:0]   step_acc;
    logic [XLEN-1:0]   step_rem;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_result;

    // funct7 is guaranteed by the decoder; only funct3 selects the operation
    logic unused_instr;
    assign unused_instr = (i_instruction[31:25] != FUNCT7_MULDIV) ^ (^i_instruction[11:0]);

    assign o_ready = (state == ST_IDLE);
    assign o_valid = (state == ST_DONE);

    assign req_f3   = funct3_e'(i_instruction[14:12]);
    assign a_neg    = op1_signed(req_f3) & i_op1[XLEN-1];
    assign b_neg    = op2_signed(req_f3) & i_op2[XLEN-1];
    assign a_mag    = a_neg ? -i_op1 : i_op1;
    assign b_mag    = b_neg ? -i_op2 : i_op2;
    assign div_zero = (i_op2 == '0);
    assign overflow = (req_f3 inside {FUNCT3_DIV, FUNCT3_REM}) &&
                      (i_op1 == INT_MIN) && (i_op2 == '1);
    assign early    = EARLY_OUT && is_div(req_f3) && (div_zero || overflow);
    assign special  = is_rem(req_f3) ? (div_zero ? i_op1 : '0)
                                     : (div_zero ? '1    : i_op1);
    assign accept    = i_valid && (state == ST_IDLE) && !i_flush;
    assign last_iter = (state == ST_BUSY) && (cnt == CNT_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)         state_next = early ? ST_DONE : ST_BUSY;
            ST_BUSY: if (last_iter)      state_next = ST_DONE;
            ST_DONE: if (i_ready)        state_next = ST_IDLE;
            default:                     state_next = ST_IDLE;
        endcase
        if (i_flush) begin
            state_next = ST_IDLE;
        end
    end

    assign step_mode = is_div(f3) ? STEP_DIV : STEP_MUL;

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .mode     (step_mode),
        .acc      (acc),
        .rem      (rem),
        .operand  (opnd),
        .acc_next (step_acc),
        .rem_next (step_rem)
    );

    // Sign fix-up; a zero divisor leaves neg_main clear so the quotient stays all ones
    always_comb begin
        prod_fix     = neg_main ? -{step_acc, step_rem} : {step_acc, step_rem};
        quo_fix      = neg_main ? -step_acc : step_acc;
        rem_fix      = neg_rem  ? -step_rem : step_rem;
        final_result = '0;
        case (f3)
            FUNCT3_MUL:                                final_result = prod_fix[XLEN-1:0];
            FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU:  final_result = prod_fix[2*XLEN-1:XLEN];
            FUNCT3_DIV, FUNCT3_DIVU:                   final_result = quo_fix;
            FUNCT3_REM, FUNCT3_REMU:                   final_result = rem_fix;
            default:                                   final_result = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            f3       <= FUNCT3_MUL;
            acc      <= '0;
            rem      <= '0;
            opnd     <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            o_result <= '0;
        end else if (accept) begin
            f3       <= req_f3;
            opnd     <= b_mag;
            cnt      <= CNT_W'(XLEN);
            neg_main <= (a_neg ^ b_neg) & !div_zero;
            neg_rem  <= a_neg;
            if (is_div(req_f3)) begin
                acc <= a_mag;
                rem <= '0;
            end else begin
                acc <= '0;
                rem <= a_mag;
            end
            if (early) begin
                o_result <= special;
            end
        end else if ((state == ST_BUSY) && !i_flush) begin
            acc <= step_acc;
            rem <= step_rem;
            cnt <= cnt - CNT_W'(1);
            if (last_iter) begin
                o_result <= final_result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: two units (EARLY_OUT=1 and 0) driven with directed and
// random RV32M ops, checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  vld;
    logic [1:0]  ordy;
    logic [1:0]  ov;
    logic [31:0] res [2];
    logic [31:0] instr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        rdy;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut_eo (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .o_ready(ordy[0]),
        .i_instruction(instr), .i_op1(op1), .i_op2(op2), .i_flush(flush),
        .o_valid(ov[0]), .i_ready(rdy), .o_result(res[0])
    );

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut_full (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .o_ready(ordy[1]),
        .i_instruction(instr), .i_op1(op1), .i_op2(op2), .i_flush(flush),
        .o_valid(ov[1]), .i_ready(rdy), .o_result(res[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'(a);
        ub = longint'(b);
        ia = a;
        ib = b;
        case (f3)
            3'd0: begin p = ua * ub;          return p[31:0];  end
            3'd1: begin p = sa * sb;          return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;          return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned exp_latency(input int unsigned sel, input logic [2:0] f3,
                                                input logic [31:0] a, input logic [31:0] b);
        logic spec_case;
        spec_case = (f3 >= 3'd4) && ((b == 0) ||
                    ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return (sel == 0 && spec_case) ? 1 : 33;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request, then counts cycles (accept cycle excluded) until o_valid
    task automatic issue(input int unsigned sel, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, output int unsigned n);
        instr    = {7'b0000001, 10'd0, f3, 5'd0, 7'b0110011};
        op1      = a;
        op2      = b;
        vld[sel] = 1'b1;
        @(posedge clk); #1;
        vld[sel] = 1'b0;
        n = 1;
        while (!ov[sel] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input int unsigned sel, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int unsigned n;
        logic [31:0] exp;
        exp = ref_model(f3, a, b);
        chk($sformatf("ready_before d%0d", sel), {31'd0, ordy[sel]}, 32'd1);
        issue(sel, f3, a, b, n);
        chk($sformatf("latency d%0d f3=%0d a=%h b=%h", sel, f3, a, b), n, exp_latency(sel, f3, a, b));
        chk($sformatf("result d%0d f3=%0d a=%h b=%h", sel, f3, a, b), res[sel], exp);
        @(posedge clk); #1;
        chk($sformatf("idle_after d%0d", sel), {31'd0, ordy[sel]}, 32'd1);
    endtask

    initial begin
        int unsigned n;
        logic [2:0]  f3;
        logic [31:0] a, b, exp;

        rst_n = 1'b0; vld = 2'b00; instr = '0; op1 = '0; op2 = '0; flush = 1'b0; rdy = 1'b1;
        #1;
        chk("reset ready", {30'd0, ordy}, 32'd3);
        chk("reset valid", {30'd0, ov}, 32'd0);
        chk("reset result eo", res[0], 32'd0);
        chk("reset result full", res[1], 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int s = 0; s < 2; s++) begin
            run_op(s, 3'd0, 32'd7,        32'hFFFF_FFFD);
            run_op(s, 3'd1, 32'h8000_0000, 32'h8000_0000);
            run_op(s, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            run_op(s, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            run_op(s, 3'd4, 32'hFFFF_FFF9, 32'd2);
            run_op(s, 3'd6, 32'hFFFF_FFF9, 32'd2);
            run_op(s, 3'd5, 32'hFFFF_FFF9, 32'd2);
            run_op(s, 3'd5, 32'd5,        32'd0);
            run_op(s, 3'd6, 32'd5,        32'd0);
            run_op(s, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
            run_op(s, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
            run_op(s, 3'd4, 32'hFFFF_FFF6, 32'd0);
        end

        for (int i = 0; i < 24; i++) begin
            int unsigned r;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r == 2) b = $urandom_range(1, 15);
            run_op(i % 2, f3, a, b);
        end

        // Flush at t+10 of a DIV, then a MULHU accepted at t+11
        instr = {7'b0000001, 10'd0, 3'd4, 5'd0, 7'b0110011};
        op1 = 32'd1000; op2 = 32'd7; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush ready", {31'd0, ordy[0]}, 32'd1);
        chk("flush valid", {31'd0, ov[0]}, 32'd0);
        run_op(0, 3'd3, 32'hDEAD_BEEF, 32'h1234_5678);

        // Flush coinciding with a request: request must be dropped
        instr = {7'b0000001, 10'd0, 3'd0, 5'd0, 7'b0110011};
        vld[0] = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        chk("flush_vs_valid ready", {31'd0, ordy[0]}, 32'd1);

        // Backpressure for 5 cycles after o_valid
        rdy = 1'b0;
        a = $urandom; b = $urandom_range(1, 1000);
        exp = ref_model(3'd4, a, b);
        issue(0, 3'd4, a, b, n);
        chk("bp latency", n, 32'd33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp valid", {31'd0, ov[0]}, 32'd1);
            chk("bp result", res[0], exp);
            chk("bp ready", {31'd0, ordy[0]}, 32'd0);
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp release ready", {31'd0, ordy[0]}, 32'd1);
        chk("bp release valid", {31'd0, ov[0]}, 32'd0);

        // Asynchronous reset in the middle of BUSY
        instr = {7'b0000001, 10'd0, 3'd1, 5'd0, 7'b0110011};
        op1 = $urandom; op2 = $urandom; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midreset valid", {31'd0, ov[0]}, 32'd0);
        chk("midreset ready", {31'd0, ordy[0]}, 32'd1);
        chk("midreset result", res[0], 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 3'd7, 32'd100, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
